ttl_serial_addsub: RTL and testbench



---
 rtl/ttl_alu_pkg.sv | 17 +
 rtl/ttl_serial_addsub_if.sv | 25 ++
 rtl/ttl_serial_addsub_slice.sv | 23 ++
 rtl/ttl_serial_addsub.sv | 130 +++++++++++++
 tb/tb_ttl_serial_addsub.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ttl_alu_pkg.sv
// Shared encodings for the slice-serial add/sub unit: operation codes and FSM states.
package ttl_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_NEG  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/ttl_serial_addsub_if.sv
// Request/result bundle between the operand registers, the add/sub unit and the result latch.
interface ttl_serial_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  result, carry_out, overflow, zero, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output result, carry_out, overflow, zero, busy, done
  );
endinterface

// File: rtl/ttl_serial_addsub_slice.sv
// Combinational SLICE_WIDTH-bit adder modelled on a 74LS283 stage.
// PROPAGATION_DELAY documents the part's settle time; the model itself is zero-delay.
module adder_slice #(
  parameter int SLICE_WIDTH       = 4,
  parameter int PROPAGATION_DELAY = 0
) (
  input  logic [SLICE_WIDTH-1:0] a_i,
  input  logic [SLICE_WIDTH-1:0] b_i,
  input  logic                   c_i,
  output logic [SLICE_WIDTH-1:0] sum_o,
  output logic                   c_o
);

  if (PROPAGATION_DELAY < 0) begin : g_bad_delay
    $error("adder_slice: PROPAGATION_DELAY must be non-negative");
  end

  // Ripple sum of one slice plus incoming carry.
  always_comb begin
    {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SLICE_WIDTH{1'b0}}, c_i};
  end

endmodule

// File: rtl/ttl_serial_addsub.sv
// Slice-serial adder/subtractor: one slice per clock, LSB first, carry held in a flop.
// Subtract/negate are done as A + ~B + 1 with A forced to 0 for negate.
module ttl_serial_addsub
  import ttl_alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SLICE_WIDTH = 4,
  parameter int SLICE_DELAY = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  ttl_serial_addsub_if.slave  bus
);

  localparam int N  = WIDTH / SLICE_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % SLICE_WIDTH) != 0 || WIDTH < SLICE_WIDTH) begin : g_bad_width
    $error("ttl_serial_addsub: WIDTH must be a non-zero multiple of SLICE_WIDTH");
  end

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   cff_q, cff_d;
  logic                   cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, done_q, done_d;

  logic [SLICE_WIDTH-1:0] slice_sum;
  logic                   slice_co;
  logic [WIDTH-1:0]       res_shift;

  adder_slice #(
    .SLICE_WIDTH      (SLICE_WIDTH),
    .PROPAGATION_DELAY(SLICE_DELAY)
  ) u_slice (
    .a_i  (a_q[SLICE_WIDTH-1:0]),
    .b_i  (b_q[SLICE_WIDTH-1:0]),
    .c_i  (cff_q),
    .sum_o(slice_sum),
    .c_o  (slice_co)
  );

  // New slice enters the result from the MSB end; after N slices the word is aligned.
  if (N == 1) begin : g_res_one
    assign res_shift = slice_sum;
  end else begin : g_res_many
    assign res_shift = {slice_sum, res_q[WIDTH-1:SLICE_WIDTH]};
  end

  // Next-state, datapath shifts and flag capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    cff_d   = cff_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      S_RUN: begin
        a_d   = a_q >> SLICE_WIDTH;
        b_d   = b_q >> SLICE_WIDTH;
        res_d = res_shift;
        cff_d = slice_co;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(N - 1)) begin
          // Top slice still holds the effective operand sign bits.
          cout_d  = slice_co;
          ovf_d   = (a_q[SLICE_WIDTH-1] == b_q[SLICE_WIDTH-1]) &&
                    (slice_sum[SLICE_WIDTH-1] != a_q[SLICE_WIDTH-1]);
          zero_d  = (res_shift == '0);
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      default: begin
        if (bus.start) begin
          case (op_e'(bus.op))
            OP_SUB:  begin a_d = bus.a; b_d = ~bus.b; cff_d = 1'b1; end
            OP_NEG:  begin a_d = '0;    b_d = ~bus.b; cff_d = 1'b1; end
            default: begin a_d = bus.a; b_d = bus.b;  cff_d = 1'b0; end
          endcase
          idx_d   = '0;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      cff_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      cff_q   <= cff_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign bus.result    = res_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ttl_serial_addsub.sv
// Bench for ttl_serial_addsub: directed plan vectors, random ops against an arithmetic model,
// start-while-busy, back-to-back and mid-operation reset scenarios.
module tb_ttl_serial_addsub;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  ttl_serial_addsub_if #(.WIDTH(32)) bus ();

  ttl_serial_addsub #(.WIDTH(32), .SLICE_WIDTH(4), .SLICE_DELAY(0)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference: signed/unsigned arithmetic on the operation's meaning.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic v,
                                output logic z);
    longint sa, sb, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b01: begin sr = sa - sb; r = a - b; c = (a >= b); end
      2'b10: begin sr = -sb;     r = 32'd0 - b; c = (b == 32'd0); end
      default: begin
        sr = sa + sb; r = a + b;
        c  = ((longint'(a) + longint'(b)) > 64'sd4294967295);
      end
    endcase
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    z = (r == 32'd0);
  endfunction

  // Issue one op; lat = negedges after the accepting edge until done (-1 on timeout).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit busy_bad);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
    busy_bad = !bus.busy;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        if (bus.busy) busy_bad = 1'b1;
        break;
      end
      if (!bus.busy) busy_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", bus.carry_out); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
    if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=0", bus.zero); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [9] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b11};
    logic [31:0] t_a  [9] = '{32'h0000_000F, 32'd5, 32'd7, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                              32'h0, 32'h0, 32'h0, 32'h1234_5678};
    logic [31:0] t_b  [9] = '{32'h1, 32'd7, 32'd5, 32'h1, 32'h1, 32'h1, 32'h8000_0000, 32'h0,
                              32'h1111_1111};
    logic [31:0] t_r  [9] = '{32'h10, 32'hFFFF_FFFE, 32'h2, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'h0, 32'h2345_6789};
    logic [3:0]  t_cvz[9] = '{4'b000, 4'b000, 4'b100, 4'b010, 4'b101, 4'b000, 4'b010, 4'b101,
                              4'b000};
    int lat; bit bb; logic [2:0] cvz;
    for (int k = 0; k < 9; k++) begin
      run_op(t_op[k], t_a[k], t_b[k], lat, bb);
      cvz = {bus.carry_out, bus.overflow, bus.zero};
      checks += 4;
      if (lat !== 8) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=8", k, lat); end
      if (bb) begin errors++; $display("FAIL dir%0d_busy busy not high through run", k); end
      if (bus.result !== t_r[k]) begin
        errors++; $display("FAIL dir%0d_result got=%h exp=%h", k, bus.result, t_r[k]);
      end
      if (cvz !== t_cvz[k][2:0]) begin
        errors++; $display("FAIL dir%0d_flags cvz got=%b exp=%b", k, cvz, t_cvz[k][2:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] corner [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] a, b, er; logic [1:0] op; logic ec, ev, ez; int lat; bit bb;
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      model(op, a, b, er, ec, ev, ez);
      run_op(op, a, b, lat, bb);
      checks += 3;
      if (lat !== 8) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=8", k, lat); end
      if (bus.result !== er) begin
        errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h exp=%h", k, op, a, b, bus.result, er);
      end
      if ({bus.carry_out, bus.overflow, bus.zero} !== {ec, ev, ez}) begin
        errors++; $display("FAIL rnd%0d_flags op=%0d a=%h b=%h cvz got=%b exp=%b", k, op, a, b,
                           {bus.carry_out, bus.overflow, bus.zero}, {ec, ev, ez});
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] er; logic ec, ev, ez; int lat;
    model(2'b00, 32'h0000_1234, 32'h0000_0FFF, er, ec, ev, ez);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h0000_1234; bus.b = 32'h0000_0FFF;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin lat = i; break; end
      bus.start = (i == 2 || i == 5);
      bus.op = 2'b01; bus.a = $urandom; bus.b = $urandom;
    end
    bus.start = 1'b0;
    checks += 3;
    if (lat !== 8) begin errors++; $display("FAIL ign_latency got=%0d exp=8", lat); end
    if (bus.result !== er) begin errors++; $display("FAIL ign_result got=%h exp=%h", bus.result, er); end
    @(negedge clk);
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL ign_pulse done=%b busy=%b exp done=0 busy=0", bus.done, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er; logic ec, ev, ez; int lat; bit bb;
    model(2'b01, 32'd100, 32'd1, er, ec, ev, ez);
    run_op(2'b01, 32'd100, 32'd1, lat, bb);
    checks += 3;
    if (bus.result !== er) begin errors++; $display("FAIL b2b_first got=%h exp=%h", bus.result, er); end
    // Start held during the done cycle must be accepted.
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'hDEAD_BEEF; bus.b = 32'h0000_0003;
    model(2'b10, 32'hDEAD_BEEF, 32'h0000_0003, er, ec, ev, ez);
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin lat = i; break; end
    end
    if (lat !== 8) begin errors++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
    if ({bus.result, bus.carry_out, bus.overflow, bus.zero} !== {er, ec, ev, ez}) begin
      errors++; $display("FAIL b2b_second got=%h/%b exp=%h/%b", bus.result,
                         {bus.carry_out, bus.overflow, bus.zero}, er, {ec, ev, ez});
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] er; logic ec, ev, ez; int lat; bit bb; bit seen;
    // Leave nonzero flags behind so the clear is observable.
    run_op(2'b00, 32'hFFFF_FFFF, 32'h1, lat, bb);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h7FFF_FFFF; bus.b = 32'h7FFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL mrst_ctrl busy=%b done=%b exp 0 0", bus.busy, bus.done);
    end
    if ({bus.result, bus.carry_out, bus.overflow, bus.zero} !== 35'd0) begin
      errors++; $display("FAIL mrst_outputs got=%h/%b exp=0/000", bus.result,
                         {bus.carry_out, bus.overflow, bus.zero});
    end
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    if (seen) begin errors++; $display("FAIL mrst_no_done got=activity exp=idle"); end
    model(2'b01, 32'h8000_0000, 32'h1, er, ec, ev, ez);
    run_op(2'b01, 32'h8000_0000, 32'h1, lat, bb);
    checks += 2;
    if (lat !== 8) begin errors++; $display("FAIL mrst_after_latency got=%0d exp=8", lat); end
    if ({bus.result, bus.carry_out, bus.overflow, bus.zero} !== {er, ec, ev, ez}) begin
      errors++; $display("FAIL mrst_after_result got=%h/%b exp=%h/%b", bus.result,
                         {bus.carry_out, bus.overflow, bus.zero}, er, {ec, ev, ez});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
